serial_logic_unit: RTL and testbench



---
 rtl/serial_logic_unit.sv | 108 ++++++++++
 tb/tb_serial_logic_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: latches two operands on start, evaluates
// AND/OR/XOR/NAND one bit per clock LSB-first, then publishes the packed
// result with a one-cycle done pulse and a zero flag.
module serial_logic_unit #(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] result,
    output logic            zero
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [size-1:0] sa_q, sb_q, acc_q, acc_d, result_q;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, zero_q;
    logic            bit_d;

    // Single gate slice: one result bit from the low bits of the operand shifters
    always_comb begin
        bit_d = 1'b0;
        case (op_q)
            2'b00: bit_d = sa_q[0] & sb_q[0];
            2'b01: bit_d = sa_q[0] | sb_q[0];
            2'b10: bit_d = sa_q[0] ^ sb_q[0];
            2'b11: bit_d = ~(sa_q[0] & sb_q[0]);
            default: bit_d = 1'b0;
        endcase
    end

    // Accumulator shifts right so the first (LSB) bit ends up in bit 0
    always_comb begin
        acc_d           = acc_q >> 1;
        acc_d[size-1]   = bit_d;
    end

    // Control FSM with registered outputs; result/zero only move at completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        op_q    <= op;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    acc_q <= acc_d;
                    if (cnt_q == LAST) begin
                        // Counter stops at size-1, so it never needs to wrap
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit: table vectors, randomized ops
// against a parallel bitwise model, back-to-back starts, mid-op reset, size=1.
module tb_serial_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       busy, done, zero;
    logic [7:0] result;

    logic       start1;
    logic [1:0] op1;
    logic [0:0] a1, b1;
    logic       busy1, done1, zero1;
    logic [0:0] result1;

    int errs   = 0;
    int checks = 0;
    logic [7:0] prev_res;
    logic       prev_zero;

    always #5 clk = ~clk;

    serial_logic_unit #(.size(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    serial_logic_unit #(.size(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .zero(zero1)
    );

    // Reference: whole-word bitwise operation, no serialization involved
    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One operation on the size-8 unit; noisy drives start/operands while busy
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xo,
                         input logic [7:0] er, input logic ez, input string tag, input bit noisy);
        int n;
        @(negedge clk);
        a = xa; b = xb; op = xo; start = 1'b1;
        @(negedge clk);
        n = 1;
        while (!done && n < 40) begin
            chk({tag, " busy_run"}, busy, 1);
            chk({tag, " result_held"}, result, prev_res);
            chk({tag, " zero_held"}, zero, prev_zero);
            start = noisy ? 1'($urandom) : 1'b0;
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 9);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_done"}, busy, 1);
        chk({tag, " result"}, result, er);
        chk({tag, " zero"}, zero, ez);
        prev_res  = er;
        prev_zero = ez;
        start = noisy;   // start in the DONE cycle must be ignored
        a = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_idle"}, busy, 0);
        chk({tag, " result_after"}, result, er);
    endtask

    typedef struct {
        logic [7:0] va, vb;
        logic [1:0] vo;
        logic [7:0] res;
        logic       z;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [7:0] ha[64], hb[64];
        logic [1:0] ho[64];
        int ndone, last, cnt;

        vt[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0};
        vt[1] = '{8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b0};
        vt[2] = '{8'hA5, 8'h0F, 2'b10, 8'hAA, 1'b0};
        vt[3] = '{8'hA5, 8'h0F, 2'b11, 8'hFA, 1'b0};
        vt[4] = '{8'hA5, 8'h5A, 2'b00, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
        @(negedge clk); @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst zero", zero, 1);
        chk("rst1 busy", busy1, 0);
        chk("rst1 zero", zero1, 1);
        rst = 1'b0;
        prev_res = 8'h00; prev_zero = 1'b1;

        for (int i = 0; i < 5; i++)
            do_op(vt[i].va, vt[i].vb, vt[i].vo, vt[i].res, vt[i].z, $sformatf("vec%0d", i), i[0]);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb, er;
            logic [1:0] ro;
            ra = 8'($urandom); rb = 8'($urandom); ro = 2'($urandom);
            er = model(ro, ra, rb);
            do_op(ra, rb, ro, er, er == 8'h00, $sformatf("rnd%0d", i), 1'b1);
        end

        // start held high with operands changing every cycle
        ndone = 0; last = -1;
        for (int c = 0; c < 53; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (c >= 9) chk("b2b result", result, model(ho[c-9], ha[c-9], hb[c-9]));
                else chk("b2b early_done", c, 9);
                if (last >= 0) chk("b2b period", c - last, 10);
                else chk("b2b first", c, 9);
                last = c;
            end
            ha[c] = 8'($urandom); hb[c] = 8'($urandom); ho[c] = 2'($urandom);
            a = ha[c]; b = hb[c]; op = ho[c];
            start = (c <= 40);
        end
        chk("b2b count", ndone, 5);
        prev_res  = model(ho[40], ha[40], hb[40]);
        prev_zero = (prev_res == 8'h00);

        // reset asserted during the 4th RUN cycle
        @(negedge clk);
        a = 8'h3C; b = 8'hFF; op = 2'b01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        chk("midrst zero", zero, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("midrst no_done", cnt, 0);
        prev_res = 8'h00; prev_zero = 1'b1;
        do_op(8'hFF, 8'hFF, 2'b00, 8'hFF, 1'b0, "after_rst", 1'b0);

        // size=1 instance
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; op1 = 2'b11; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; a1 = 1'b0;
        chk("s1 nand done_c1", done1, 0);
        chk("s1 nand busy_c1", busy1, 1);
        @(negedge clk);
        chk("s1 nand done_c2", done1, 1);
        chk("s1 nand result", result1, 0);
        chk("s1 nand zero", zero1, 1);
        @(negedge clk);
        chk("s1 nand idle", busy1, 0);
        a1 = 1'b1; b1 = 1'b0; op1 = 2'b10; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("s1 xor held", result1, 0);
        @(negedge clk);
        chk("s1 xor done", done1, 1);
        chk("s1 xor result", result1, 1);
        chk("s1 xor zero", zero1, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
